card_shoe: RTL and testbench

//  Parametrised multi-deck card source for the baccarat engine. Replaces the free-running

---
 rtl/card_shoe.sv | 112 +++++++++++
 tb/tb_card_shoe.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_shoe.sv
// Multi-deck card shoe: deals ranks 1..13 without replacement, tracks the remaining
// count, flags the cut card and refills all ranks on a shuffle request.
module card_shoe #(
    parameter int          NUM_DECKS = 1,
    parameter int          CUT_CARDS = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         RW        = $clog2(4 * NUM_DECKS + 1),
    localparam int         CW        = $clog2(52 * NUM_DECKS + 1)
) (
    input  logic          slow_clock,
    input  logic          resetb,
    input  logic          deal_req,
    input  logic          shuffle_req,
    output logic          card_valid,
    output logic [3:0]    card,
    output logic [CW-1:0] cards_left,
    output logic          busy,
    output logic          shuffling,
    output logic          cut_reached,
    output logic [1:0]    state_dbg
);
    // Handshake: deal_req/shuffle_req are level requests sampled only in IDLE (ignored,
    // not queued, while busy); card_valid is a one-cycle pulse with no back-pressure.
    typedef enum logic [1:0] {IDLE, SEARCH, DELIVER, SHUFFLE} state_e;

    localparam logic [RW-1:0] RANK_FULL = RW'(4 * NUM_DECKS);
    localparam logic [CW-1:0] SHOE_FULL = CW'(52 * NUM_DECKS);

    state_e        state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    card_q, card_d;
    logic [CW-1:0] cards_left_q, cards_left_d;
    logic [RW-1:0] rank_cnt_q [1:13];
    logic [RW-1:0] rank_cnt_d [1:13];

    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            state_q      <= IDLE;
            lfsr_q       <= LFSR_SEED;
            cand_q       <= 4'd1;
            card_q       <= 4'd0;
            cards_left_q <= SHOE_FULL;
            for (int i = 1; i <= 13; i++) rank_cnt_q[i] <= RANK_FULL;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            cand_q       <= cand_d;
            card_q       <= card_d;
            cards_left_q <= cards_left_d;
            rank_cnt_q   <= rank_cnt_d;
        end
    end

    // cand_q is the rank under examination in SEARCH and the rank being refilled in SHUFFLE.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        cand_d       = cand_q;
        card_d       = card_q;
        cards_left_d = cards_left_q;
        rank_cnt_d   = rank_cnt_q;
        case (state_q)
            IDLE: begin
                if (shuffle_req) begin
                    state_d = SHUFFLE;
                    cand_d  = 4'd1;
                end else if (deal_req) begin
                    if (cards_left_q == '0) begin
                        card_d  = 4'd0;
                        state_d = DELIVER;
                    end else begin
                        cand_d  = (lfsr_q[3:0] <= 4'd12) ? lfsr_q[3:0] + 4'd1
                                                         : lfsr_q[3:0] - 4'd12;
                        state_d = SEARCH;
                    end
                end
            end
            SEARCH: begin
                if (rank_cnt_q[cand_q] != '0) begin
                    rank_cnt_d[cand_q] = rank_cnt_q[cand_q] - RW'(1);
                    cards_left_d       = cards_left_q - CW'(1);
                    card_d             = cand_q;
                    state_d            = DELIVER;
                end else begin
                    cand_d = (cand_q == 4'd13) ? 4'd1 : cand_q + 4'd1;
                end
            end
            DELIVER: state_d = IDLE;
            SHUFFLE: begin
                rank_cnt_d[cand_q] = RANK_FULL;
                if (cand_q == 4'd13) begin
                    cards_left_d = SHOE_FULL;
                    lfsr_d       = LFSR_SEED;
                    card_d       = 4'd0;
                    state_d      = IDLE;
                end else begin
                    cand_d = cand_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign card_valid  = (state_q == DELIVER);
    assign card        = card_q;
    assign cards_left  = cards_left_q;
    assign busy        = (state_q != IDLE);
    assign shuffling   = (state_q == SHUFFLE);
    assign cut_reached = (32'(cards_left_q) <= CUT_CARDS);
    assign state_dbg   = state_q;
endmodule

// File: tb/tb_card_shoe.sv
// Bench for card_shoe: a one-deck and a two-deck shoe driven side by side and checked
// against a rank-count model of the shoe with random idle gaps between deals.
module tb_card_shoe;
  localparam logic [15:0] SEED = 16'hACE1;

  logic slow_clock = 1'b0;
  logic resetb = 1'b0;
  logic deal_req [2];
  logic shuffle_req [2];
  logic cv [2];
  logic [3:0] cd [2];
  logic [7:0] cl [2];
  logic busy_w [2];
  logic shuf_w [2];
  logic cut_w [2];
  logic [1:0] st [2];
  logic [5:0] cl1;
  logic [6:0] cl2;

  always #5 slow_clock = ~slow_clock;

  card_shoe #(.NUM_DECKS(1), .CUT_CARDS(8), .LFSR_SEED(SEED)) u_d1 (
    .slow_clock(slow_clock), .resetb(resetb), .deal_req(deal_req[0]),
    .shuffle_req(shuffle_req[0]), .card_valid(cv[0]), .card(cd[0]), .cards_left(cl1),
    .busy(busy_w[0]), .shuffling(shuf_w[0]), .cut_reached(cut_w[0]), .state_dbg(st[0]));

  card_shoe #(.NUM_DECKS(2), .CUT_CARDS(20), .LFSR_SEED(SEED)) u_d2 (
    .slow_clock(slow_clock), .resetb(resetb), .deal_req(deal_req[1]),
    .shuffle_req(shuffle_req[1]), .card_valid(cv[1]), .card(cd[1]), .cards_left(cl2),
    .busy(busy_w[1]), .shuffling(shuf_w[1]), .cut_reached(cut_w[1]), .state_dbg(st[1]));

  assign cl[0] = {2'b00, cl1};
  assign cl[1] = {1'b0, cl2};

  // reference model
  int nd [2] = '{1, 2};
  int cut [2] = '{8, 20};
  int m_cnt [2][14];
  int m_left [2];
  logic [15:0] m_lfsr [2];
  int m_shuf [2];
  int dealt [2][14];
  int n_cmp = 0;
  int n_bad = 0;
  int pu_first = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic void model_full(input int j);
    for (int r = 1; r <= 13; r++) m_cnt[j][r] = 4 * nd[j];
    m_left[j] = 52 * nd[j];
  endfunction

  task automatic tick();
    @(posedge slow_clock);
    for (int j = 0; j < 2; j++) begin
      if (!resetb) begin
        m_lfsr[j] = SEED;
        m_shuf[j] = 0;
      end else if (m_shuf[j] == 1) begin
        m_lfsr[j] = SEED;
        m_shuf[j] = 0;
      end else begin
        if (m_shuf[j] > 0) m_shuf[j]--;
        m_lfsr[j] = lfsr_next(m_lfsr[j]);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    tick();
    tick();
    resetb = 1'b1;
    model_full(0);
    model_full(1);
  endtask

  task automatic do_deal(input int i, input bit pulse_busy, output int got);
    int exp_card, exp_lat, lat, cand, n;
    if (m_left[i] == 0) begin
      exp_card = 0;
      exp_lat  = 1;
    end else begin
      n = int'(m_lfsr[i][3:0]);
      cand = (n <= 12) ? n + 1 : n - 12;
      exp_lat = 2;
      while (m_cnt[i][cand] == 0) begin
        cand = (cand == 13) ? 1 : cand + 1;
        exp_lat++;
      end
      exp_card = cand;
      m_cnt[i][cand]--;
      m_left[i]--;
    end
    deal_req[i] = 1'b1;
    tick();
    deal_req[i] = 1'b0;
    lat = 1;
    while (cv[i] !== 1'b1 && lat < 16) begin
      tick();
      lat++;
    end
    got = int'(cd[i]);
    n_cmp++;
    if (cv[i] !== 1'b1) begin
      n_bad++;
      $display("FAIL deal_timeout[%0d]: no card_valid after %0d cycles (state %0d), required within %0d",
               i, lat, st[i], exp_lat);
    end
    n_cmp++;
    if (lat !== exp_lat) begin
      n_bad++;
      $display("FAIL deal_latency[%0d]: got %0d required %0d", i, lat, exp_lat);
    end
    n_cmp++;
    if (got !== exp_card) begin
      n_bad++;
      $display("FAIL deal_card[%0d]: got %0d required %0d", i, got, exp_card);
    end
    n_cmp++;
    if (int'(cl[i]) !== m_left[i]) begin
      n_bad++;
      $display("FAIL cards_left[%0d]: got %0d required %0d", i, cl[i], m_left[i]);
    end
    n_cmp++;
    if (cut_w[i] !== (m_left[i] <= cut[i])) begin
      n_bad++;
      $display("FAIL cut_reached[%0d]: got %0b with cards_left %0d", i, cut_w[i], m_left[i]);
    end
    if (exp_card != 0) dealt[i][exp_card]++;
    if (pulse_busy) deal_req[i] = 1'b1;
    tick();
    deal_req[i] = 1'b0;
    n_cmp++;
    if (cv[i] !== 1'b0 || int'(cd[i]) !== exp_card) begin
      n_bad++;
      $display("FAIL pulse_width[%0d]: valid %0b card %0d, required valid 0 card %0d",
               i, cv[i], cd[i], exp_card);
    end
    if (pulse_busy) begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (cv[i] !== 1'b0 || busy_w[i] !== 1'b0) begin
          n_bad++;
          $display("FAIL busy_req_ignored[%0d]: valid %0b busy %0b, required 0 0",
                   i, cv[i], busy_w[i]);
        end
        tick();
      end
    end
  endtask

  task automatic check_idle_full(input string name);
    for (int j = 0; j < 2; j++) begin
      n_cmp++;
      if (int'(cl[j]) !== 52 * nd[j] || cd[j] !== 4'd0 || cv[j] !== 1'b0 ||
          busy_w[j] !== 1'b0 || shuf_w[j] !== 1'b0 || cut_w[j] !== 1'b0) begin
        n_bad++;
        $display("FAIL %s[%0d]: left %0d card %0d valid %0b busy %0b shuf %0b cut %0b, required %0d 0 0 0 0 0",
                 name, j, cl[j], cd[j], cv[j], busy_w[j], shuf_w[j], cut_w[j], 52 * nd[j]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_idle_full("reset_state");
  endtask

  task automatic test_deck1();
    int got;
    for (int r = 1; r <= 13; r++) dealt[0][r] = 0;
    do_deal(0, 1'b0, got);
    pu_first = got;
    for (int d = 1; d < 52; d++) begin
      repeat ($urandom_range(0, 3)) tick();
      do_deal(0, 1'b0, got);
    end
    for (int r = 1; r <= 13; r++) begin
      n_cmp++;
      if (dealt[0][r] !== 4) begin
        n_bad++;
        $display("FAIL rank_count_1deck: rank %0d dealt %0d times, required 4", r, dealt[0][r]);
      end
    end
  endtask

  task automatic test_empty();
    int got;
    do_deal(0, 1'b0, got);
    tick();
    do_deal(0, 1'b0, got);
  endtask

  task automatic test_shuffle_and_deal();
    int got;
    shuffle_req[0] = 1'b1;
    deal_req[0] = 1'b1;
    tick();
    shuffle_req[0] = 1'b0;
    deal_req[0] = 1'b0;
    m_shuf[0] = 13;
    for (int k = 1; k <= 13; k++) begin
      n_cmp++;
      if (shuf_w[0] !== 1'b1 || cv[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL shuffle_cycle %0d: shuffling %0b valid %0b, required 1 0", k, shuf_w[0], cv[0]);
      end
      tick();
    end
    model_full(0);
    n_cmp++;
    if (shuf_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || cl[0] !== 8'd52 || cd[0] !== 4'd0) begin
      n_bad++;
      $display("FAIL shuffle_done: shuf %0b busy %0b left %0d card %0d, required 0 0 52 0",
               shuf_w[0], busy_w[0], cl[0], cd[0]);
    end
    for (int d = 0; d < 4; d++) begin
      repeat ($urandom_range(0, 2)) tick();
      do_deal(0, 1'b0, got);
    end
  endtask

  task automatic test_reset_abort();
    int got;
    deal_req[0] = 1'b1;
    tick();
    deal_req[0] = 1'b0;
    n_cmp++;
    if (busy_w[0] !== 1'b1 || cv[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_search_setup: busy %0b valid %0b, required 1 0", busy_w[0], cv[0]);
    end
    resetb = 1'b0;
    tick();
    check_idle_full("abort_search");
    tick();
    resetb = 1'b1;
    model_full(0);
    model_full(1);
    do_deal(0, 1'b0, got);
    n_cmp++;
    if (got !== pu_first) begin
      n_bad++;
      $display("FAIL first_after_reset: card %0d, required %0d", got, pu_first);
    end
    shuffle_req[0] = 1'b1;
    tick();
    shuffle_req[0] = 1'b0;
    m_shuf[0] = 13;
    repeat (5) tick();
    n_cmp++;
    if (shuf_w[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_shuffle_setup: shuffling %0b, required 1", shuf_w[0]);
    end
    resetb = 1'b0;
    tick();
    check_idle_full("abort_shuffle");
    tick();
    resetb = 1'b1;
    model_full(0);
    model_full(1);
  endtask

  task automatic test_deck2();
    int got;
    int first_cut = -1;
    do_reset();
    for (int r = 1; r <= 13; r++) dealt[1][r] = 0;
    for (int d = 0; d < 104; d++) begin
      repeat ($urandom_range(0, 3)) tick();
      do_deal(1, (d % 10) == 5, got);
      if (first_cut < 0 && cut_w[1] === 1'b1) first_cut = int'(cl[1]);
    end
    for (int r = 1; r <= 13; r++) begin
      n_cmp++;
      if (dealt[1][r] !== 8) begin
        n_bad++;
        $display("FAIL rank_count_2deck: rank %0d dealt %0d times, required 8", r, dealt[1][r]);
      end
    end
    n_cmp++;
    if (first_cut !== 20) begin
      n_bad++;
      $display("FAIL first_cut_2deck: first seen at cards_left %0d, required 20", first_cut);
    end
  endtask

  initial begin
    deal_req = '{1'b0, 1'b0};
    shuffle_req = '{1'b0, 1'b0};
    m_shuf = '{0, 0};
    m_lfsr = '{SEED, SEED};
    test_reset();
    test_deck1();
    test_empty();
    test_shuffle_and_deal();
    test_reset_abort();
    test_deck2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
